axi_bridge: RTL and testbench
=============================

AXI_BRIDGE -- requirements
Module: axi_bridge

Interface
REQ-001 Parameter INST_ID, default 4'd0, SHALL be the arid used for instruction reads.
REQ-002 Parameter DATA_ID, default 4'd1, SHALL be the arid/awid used for data accesses.
REQ-003 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 inst_req/inst_size/inst_addr  in  1/2/32  instruction read request (read-only port).
REQ-006 inst_addr_ok/inst_data_ok/inst_rdata  out  1/1/32  request accepted / read data valid / read data.
REQ-007 data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata  in  1/1/2/4/32/32  data request.
REQ-008 data_addr_ok/data_data_ok/data_rdata  out  1/1/32  data accept / completion / read data.
REQ-009 arid/araddr/arsize/arvalid  out  4/32/3/1; arready  in  1  AXI read-address channel.
REQ-010 rid/rdata/rvalid  in  4/32/1; rready  out  1  AXI read-data channel.
REQ-011 awid/awaddr/awsize/awvalid  out  4/32/3/1; awready  in  1  AXI write-address channel.
REQ-012 wdata/wstrb/wvalid  out  32/4/1; wready  in  1  AXI write-data channel.
REQ-013 bvalid  in  1; bready  out  1  AXI write-response channel.
REQ-014 arlen/awlen SHALL be tied to 0, arburst/awburst to 2'b01, lock/cache/prot to 0, wid to DATA_ID, wlast to 1.

Function
REQ-015 Read FSM states R_IDLE, R_ADDR, R_DATA; write FSM states W_IDLE, W_ADDR, W_RESP; at most one read and one write outstanding.
REQ-016 In R_IDLE, data read (data_req & ~data_wr) SHALL win over inst_req; the loser SHALL see addr_ok=0 that cycle.
REQ-017 addr_ok SHALL be combinational, same cycle as req, only when the target FSM is idle; accept moves R_IDLE->R_ADDR or W_IDLE->W_ADDR.
REQ-018 A data read SHALL NOT be accepted while the write FSM is not W_IDLE (read-after-write ordering).
REQ-019 A data write SHALL NOT be accepted while the read FSM holds a data read.
REQ-020 arvalid SHALL assert the cycle after accept with registered araddr/arid/arsize={1'b0,size}, held stable until arready; then R_DATA.
REQ-021 rready SHALL be 1 only in R_DATA; on rvalid&rready, data_ok for the port matching rid SHALL pulse one cycle with rdata passed through, then R_IDLE.
REQ-022 awvalid and wvalid SHALL both assert the cycle after write accept; each SHALL drop independently on its own handshake; W_RESP entered once both have completed (same or different cycles).
REQ-023 bready SHALL be 1 only in W_RESP; on bvalid, data_data_ok SHALL pulse one cycle, then W_IDLE.
REQ-024 Read and write FSMs SHALL run concurrently; a read and write data_ok in the same cycle are impossible by REQ-018/019.
REQ-025 rvalid with an unexpected rid, or bvalid outside W_RESP, SHALL be ignored.

Reset
REQ-026 On resetn=0, both FSMs SHALL go idle asynchronously; all valid/ready/ok outputs SHALL be 0, address/data registers 0.
REQ-027 Reset mid-transaction SHALL abandon the outstanding transaction with no data_ok issued.

Structure
REQ-028 FSM state encodings and AXI constant fields SHALL live in the shared macro header.
REQ-029 Single module; no sub-modules.

Verification
REQ-030 inst_req, addr 0x1c000000, arready=1, rvalid 2 cycles later with rid=0, rdata=0x02800c0c -> inst_addr_ok same cycle, arvalid next cycle, inst_data_ok one cycle with rdata 0x02800c0c.
REQ-031 inst_req and data read in same cycle -> data_addr_ok=1, inst_addr_ok=0, arid=1; inst accepted after data rvalid.
REQ-032 Data write addr 0x8, wstrb 4'b0011, awready after 3 cycles, wready immediately -> wvalid drops after 1 cycle, awvalid after 3, data_data_ok on bvalid.
REQ-033 Data read issued while write in W_RESP -> data_addr_ok=0 until cycle after bvalid.
REQ-034 resetn=0 while arvalid high -> arvalid=0 immediately, no data_ok, next req accepted normally.
REQ-035 arready held low 10 cycles -> araddr/arid stable throughout, arvalid held high.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared constants for the SRAM-style to AXI bridge: FSM encodings,
// tied-off AXI channel fields and the size conversion helper.
package axi_bridge_pkg;

    localparam int unsigned AXI_ID_W = 4;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [3:0] AXI_LEN        = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_LOCK       = 2'b00;
    localparam logic [3:0] AXI_CACHE      = 4'd0;
    localparam logic [2:0] AXI_PROT       = 3'd0;

    function automatic logic [2:0] to_axsize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_bridge_if.sv
// AXI3 single-beat channel bundle; master is the bridge, slave is memory.
interface axi_bridge_if;
    import axi_bridge_pkg::*;

    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    logic                rvalid;
    logic                rready;

    logic [AXI_ID_W-1:0] awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [AXI_ID_W-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_bridge.sv
// Bridges an instruction read port and a data read/write port onto one AXI3
// master with at most one read and one write outstanding.
module axi_bridge
    import axi_bridge_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    axi_bridge_if.master axi
);

    logic [1:0]  r_state;
    logic [1:0]  w_state;
    logic        r_is_data;
    logic [31:0] araddr_q;
    logic [3:0]  arid_q;
    logic [2:0]  arsize_q;
    logic [31:0] awaddr_q;
    logic [2:0]  awsize_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;

    logic data_rd_req, data_wr_req;
    logic rd_data_acc, inst_acc, wr_acc;
    logic aw_fin, w_fin, r_hs, b_hs;

    assign data_rd_req = data_req & ~data_wr;
    assign data_wr_req = data_req & data_wr;

    // A pending data read blocks the instruction port even when the read itself
    // is held off by an outstanding write; reads never overtake a write.
    assign rd_data_acc = resetn & (r_state == R_IDLE) & data_rd_req & (w_state == W_IDLE);
    assign inst_acc    = resetn & (r_state == R_IDLE) & inst_req & ~data_rd_req;
    assign wr_acc      = resetn & (w_state == W_IDLE) & data_wr_req
                       & ~((r_state != R_IDLE) & r_is_data);

    assign aw_fin = aw_done | (axi.awvalid & axi.awready);
    assign w_fin  = w_done  | (axi.wvalid & axi.wready);
    assign r_hs   = (r_state == R_DATA) & axi.rvalid
                  & (axi.rid == (r_is_data ? DATA_ID : INST_ID));
    assign b_hs   = (w_state == W_RESP) & axi.bvalid;

    assign inst_addr_ok = inst_acc;
    assign data_addr_ok = rd_data_acc | wr_acc;
    assign inst_data_ok = r_hs & ~r_is_data;
    assign data_data_ok = (r_hs & r_is_data) | b_hs;
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= R_IDLE;
            r_is_data <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arsize_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_data_acc) begin
                        r_state   <= R_ADDR;
                        r_is_data <= 1'b1;
                        araddr_q  <= data_addr;
                        arid_q    <= DATA_ID;
                        arsize_q  <= to_axsize(data_size);
                    end else if (inst_acc) begin
                        r_state   <= R_ADDR;
                        r_is_data <= 1'b0;
                        araddr_q  <= inst_addr;
                        arid_q    <= INST_ID;
                        arsize_q  <= to_axsize(inst_size);
                    end
                end
                R_ADDR:  if (axi.arready) r_state <= R_DATA;
                R_DATA:  if (r_hs) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // awvalid and wvalid retire independently; the done flags remember which
    // half has already handshaken so the response phase waits for both.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state  <= W_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awaddr_q <= '0;
            awsize_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_acc) begin
                        w_state  <= W_ADDR;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        awaddr_q <= data_addr;
                        awsize_q <= to_axsize(data_size);
                        wdata_q  <= data_wdata;
                        wstrb_q  <= data_wstrb;
                    end
                end
                W_ADDR: begin
                    if (aw_fin & w_fin) begin
                        w_state <= W_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                W_RESP:  if (axi.bvalid) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign axi.arid    = arid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arsize  = arsize_q;
    assign axi.arlen   = AXI_LEN;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = AXI_LOCK;
    assign axi.arcache = AXI_CACHE;
    assign axi.arprot  = AXI_PROT;
    assign axi.arvalid = (r_state == R_ADDR);
    assign axi.rready  = (r_state == R_DATA);

    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awsize  = awsize_q;
    assign axi.awlen   = AXI_LEN;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = AXI_LOCK;
    assign axi.awcache = AXI_CACHE;
    assign axi.awprot  = AXI_PROT;
    assign axi.awvalid = (w_state == W_ADDR) & ~aw_done;

    assign axi.wid     = DATA_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (w_state == W_ADDR) & ~w_done;
    assign axi.bready  = (w_state == W_RESP);

endmodule

// File: tb/tb_axi_bridge.sv
// Directed bench for axi_bridge: the bench plays the AXI slave and checks
// handshakes cycle by cycle against hand-computed values.
module tb_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    axi_bridge_if axi();

    axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
        data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        axi.arready = 1'b0; axi.rid = 4'd0; axi.rdata = 32'h0; axi.rvalid = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;

        // Reset state, with a request held high to prove addr_ok is suppressed
        tick(); tick();
        #1;
        chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk1("rst_arvalid", axi.arvalid, 1'b0);
        chk1("rst_awvalid", axi.awvalid, 1'b0);
        chk1("rst_wvalid", axi.wvalid, 1'b0);
        chk1("rst_rready", axi.rready, 1'b0);
        chk1("rst_bready", axi.bready, 1'b0);
        chk32("rst_araddr", axi.araddr, 32'h0);
        chk32("const_arlen", 32'(axi.arlen), 32'd0);
        chk32("const_arburst", 32'(axi.arburst), 32'd1);
        chk32("const_wid", 32'(axi.wid), 32'd1);
        chk1("const_wlast", axi.wlast, 1'b1);
        inst_req = 1'b0;
        tick();
        resetn = 1'b1;

        // Instruction fetch
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; inst_size = 2'd2; axi.arready = 1'b1;
        #1;
        chk1("if_addr_ok", inst_addr_ok, 1'b1);
        chk1("if_data_addr_ok", data_addr_ok, 1'b0);
        tick();
        inst_req = 1'b0;
        #1;
        chk1("if_arvalid", axi.arvalid, 1'b1);
        chk32("if_araddr", axi.araddr, 32'h1c00_0000);
        chk32("if_arid", 32'(axi.arid), 32'd0);
        chk32("if_arsize", 32'(axi.arsize), 32'd2);
        tick();
        chk1("if_arvalid_drop", axi.arvalid, 1'b0);
        chk1("if_rready", axi.rready, 1'b1);
        tick();
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h0280_0c0c;
        #1;
        chk1("if_data_ok", inst_data_ok, 1'b1);
        chk32("if_rdata", inst_rdata, 32'h0280_0c0c);
        chk1("if_no_data_ok", data_data_ok, 1'b0);
        tick();
        axi.rvalid = 1'b0;
        #1;
        chk1("if_data_ok_pulse", inst_data_ok, 1'b0);
        chk1("if_rready_idle", axi.rready, 1'b0);

        // Data read beats simultaneous instruction fetch
        inst_req = 1'b1; inst_addr = 32'h1c00_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100; data_size = 2'd2;
        #1;
        chk1("arb_data_ok", data_addr_ok, 1'b1);
        chk1("arb_inst_lose", inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b0;
        #1;
        chk32("arb_arid", 32'(axi.arid), 32'd1);
        chk32("arb_araddr", axi.araddr, 32'h0000_0100);
        chk1("arb_inst_busy", inst_addr_ok, 1'b0);
        tick();
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hdead_beef;
        #1;
        chk1("badrid_data_ok", data_data_ok, 1'b0);
        chk1("badrid_inst_ok", inst_data_ok, 1'b0);
        tick();
        axi.rid = 4'd1; axi.rdata = 32'h1234_5678;
        #1;
        chk1("arb_rd_data_ok", data_data_ok, 1'b1);
        chk32("arb_rdata", data_rdata, 32'h1234_5678);
        chk1("arb_inst_wait", inst_addr_ok, 1'b0);
        tick();
        axi.rvalid = 1'b0;
        #1;
        chk1("arb_inst_accept", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        #1;
        chk32("arb_inst_arid", 32'(axi.arid), 32'd0);
        chk32("arb_inst_araddr", axi.araddr, 32'h1c00_0004);
        tick();
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'hcafe_0001;
        #1;
        chk1("arb_inst_data_ok", inst_data_ok, 1'b1);
        tick();
        axi.rvalid = 1'b0; axi.arready = 1'b0;

        // Data write: wready immediate, awready after 3 cycles
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8; data_size = 2'd1;
        data_wstrb = 4'b0011; data_wdata = 32'ha5a5_a5a5;
        axi.wready = 1'b1;
        #1;
        chk1("wr_addr_ok", data_addr_ok, 1'b1);
        tick();
        data_req = 1'b0;
        #1;
        chk1("wr_awvalid_c1", axi.awvalid, 1'b1);
        chk1("wr_wvalid_c1", axi.wvalid, 1'b1);
        chk32("wr_awaddr", axi.awaddr, 32'h8);
        chk32("wr_awsize", 32'(axi.awsize), 32'd1);
        chk32("wr_wstrb", 32'(axi.wstrb), 32'h3);
        chk32("wr_wdata", axi.wdata, 32'ha5a5_a5a5);
        chk32("wr_awid", 32'(axi.awid), 32'd1);
        tick();
        axi.wready = 1'b0;
        #1;
        chk1("wr_wvalid_c2", axi.wvalid, 1'b0);
        chk1("wr_awvalid_c2", axi.awvalid, 1'b1);
        chk1("wr_bready_c2", axi.bready, 1'b0);
        tick();
        axi.awready = 1'b1;
        #1;
        chk1("wr_awvalid_c3", axi.awvalid, 1'b1);
        tick();
        axi.awready = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h20; data_size = 2'd2;
        #1;
        chk1("wr_awvalid_done", axi.awvalid, 1'b0);
        chk1("wr_bready", axi.bready, 1'b1);
        chk1("wr_no_ok_yet", data_data_ok, 1'b0);
        chk1("raw_block_1", data_addr_ok, 1'b0);
        tick();
        axi.bvalid = 1'b1;
        #1;
        chk1("wr_data_ok", data_data_ok, 1'b1);
        chk1("raw_block_2", data_addr_ok, 1'b0);
        tick();
        axi.bvalid = 1'b0;
        #1;
        chk1("wr_bready_idle", axi.bready, 1'b0);
        chk1("wr_data_ok_pulse", data_data_ok, 1'b0);
        chk1("raw_accept", data_addr_ok, 1'b1);
        tick();
        data_req = 1'b0;

        // arready held low for 10 cycles
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("stall_arvalid", axi.arvalid, 1'b1);
            chk32("stall_araddr", axi.araddr, 32'h20);
            chk32("stall_arid", 32'(axi.arid), 32'd1);
            if (i < 9) tick();
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h30;
        #1;
        chk1("war_block", data_addr_ok, 1'b0);
        data_req = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'h0000_beef;
        #1;
        chk1("stall_data_ok", data_data_ok, 1'b1);
        chk32("stall_rdata", data_rdata, 32'h0000_beef);
        tick();
        axi.rvalid = 1'b0;
        axi.bvalid = 1'b1;
        #1;
        chk1("stray_bvalid", data_data_ok, 1'b0);
        tick();
        axi.bvalid = 1'b0;

        // Reset while arvalid is high
        inst_req = 1'b1; inst_addr = 32'h40;
        #1;
        chk1("rs_accept", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        #1;
        chk1("rs_arvalid", axi.arvalid, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("rs_arvalid_drop", axi.arvalid, 1'b0);
        chk32("rs_araddr_clr", axi.araddr, 32'h0);
        axi.rvalid = 1'b1; axi.rid = 4'd0;
        #1;
        chk1("rs_no_data_ok", inst_data_ok, 1'b0);
        tick(); tick();
        axi.rvalid = 1'b0;
        resetn = 1'b1;
        tick();
        inst_req = 1'b1; inst_addr = 32'h80; axi.arready = 1'b1;
        #1;
        chk1("rs_reaccept", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        #1;
        chk32("rs_araddr_new", axi.araddr, 32'h80);
        chk1("rs_arvalid_new", axi.arvalid, 1'b1);
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rid = 4'd0; axi.rdata = 32'h5555_aaaa;
        #1;
        chk1("rs_data_ok", inst_data_ok, 1'b1);
        chk32("rs_rdata", inst_rdata, 32'h5555_aaaa);
        tick();
        axi.rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
